// File: rtl/decoder_pkg.sv
// Package: decoder_pkg
// Shared types and helpers for the pipelined one-hot decoder.
//   dec_state_e  : issue FSM state (IDLE, SCAN)
//   onehot_dec() : k-to-2^k one-hot predecode, k <= PREDEC_MAX_W
package decoder_pkg;

    typedef enum logic {IDLE, SCAN} dec_state_e;

    // Widest predecode half supported by the helper (ADDR_W up to 16).
    localparam int PREDEC_MAX_W  = 8;
    localparam int PREDEC_MAX_OH = 2**PREDEC_MAX_W;

    // Returns a one-hot word with bit 'addr' set; bits at or above 2**w stay zero.
    function automatic logic [PREDEC_MAX_OH-1:0] onehot_dec(input int w,
                                                            input logic [PREDEC_MAX_W-1:0] addr);
        logic [PREDEC_MAX_OH-1:0] oh;
        oh = '0;
        for (int i = 0; i < PREDEC_MAX_OH; i++) begin
            if ((i < (1 << w)) && (addr == i[PREDEC_MAX_W-1:0]))
                oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/decoder_if.sv
// Interface: decoder_if
// Request and response handshake bundle for decoder_pipe_n.
//   in_valid/in_ready/in_addr/in_en/in_scan : request side
//   out_valid/out_ready/out_y/out_last      : output beat side
// master = command source / select consumer, slave = decoder.
interface decoder_if #(
    parameter int ADDR_W = 6
);
    localparam int OUT_W = 2**ADDR_W;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic              in_en;
    logic              in_scan;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_y;
    logic              out_last;

    modport master (
        output in_valid, in_addr, in_en, in_scan, out_ready,
        input  in_ready, out_valid, out_y, out_last
    );

    modport slave (
        input  in_valid, in_addr, in_en, in_scan, out_ready,
        output in_ready, out_valid, out_y, out_last
    );

endinterface

// File: rtl/decoder_predec.sv
// Module: decoder_predec
// Combinational K-to-2^K one-hot predecoder with enable.
//   en   : 0 forces an all-zero output
//   addr : K-bit select
//   oh   : 2^K-bit one-hot word
module decoder_predec
    import decoder_pkg::*;
#(
    parameter int K = 3
) (
    input  logic          en,
    input  logic [K-1:0]  addr,
    output logic [2**K-1:0] oh
);
    localparam int OH_W = 2**K;

    // Size-cast drops the helper's unused upper bits without a spare signal.
    assign oh = en ? OH_W'(onehot_dec(K, PREDEC_MAX_W'(addr))) : '0;

endmodule

// File: rtl/decoder_pipe_n.sv
// Module: decoder_pipe_n
// Two-stage pipelined ADDR_W-to-2^ADDR_W one-hot decoder with valid/ready
// on both sides and a SCAN mode that walks the select from in_addr up to
// the top output.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : decoder_if.slave (request in, select beat out)
//   busy     : FSM in SCAN or any pipeline stage holding a beat
//   out_err  : only with DECODE_ONEHOT_CHK_EN defined; flags a beat whose
//              out_y is multi-hot, or zero while enabled
// Stage 1 holds the lo/hi predecodes, en and last; stage 2 holds out_y.
module decoder_pipe_n
    import decoder_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int LO_W   = ADDR_W/2
) (
    input  logic     clk,
    input  logic     rst,
    decoder_if.slave bus,
    output logic     busy
`ifdef DECODE_ONEHOT_CHK_EN
    ,
    output logic     out_err
`endif
);
    localparam int OUT_W = 2**ADDR_W;
    localparam int HI_W  = ADDR_W - LO_W;
    localparam int LO_N  = 2**LO_W;
    localparam int HI_N  = 2**HI_W;
    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

    dec_state_e        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              scan_en, scan_en_nxt;

    logic [2:1]        vld_pipe;
    logic              s1_load, s2_load;
    logic              in_rdy;
    logic              iss, iss_en, iss_last;
    logic [ADDR_W-1:0] iss_addr;

    logic [LO_N-1:0]   lo_oh_d, lo_oh_q;
    logic [HI_N-1:0]   hi_oh_d, hi_oh_q;
    logic              en_q, last_q;
    logic [OUT_W-1:0]  y_d, y_q;
    logic              last_y_q;

    // A stage loads when empty or when its contents move on this cycle.
    assign s2_load = !vld_pipe[2] || bus.out_ready;
    assign s1_load = !vld_pipe[1] || s2_load;

    // Issue FSM: picks the address/en/last entering stage 1.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        scan_en_nxt = scan_en;
        in_rdy      = 1'b0;
        iss         = 1'b0;
        iss_addr    = cnt;
        iss_en      = scan_en;
        iss_last    = 1'b0;
        case (state)
            IDLE: begin
                in_rdy   = s1_load && !rst;
                iss      = bus.in_valid && in_rdy;
                iss_addr = bus.in_addr;
                iss_en   = bus.in_en;
                iss_last = !bus.in_scan || (bus.in_addr == ADDR_TOP);
                if (iss && !iss_last) begin
                    state_nxt   = SCAN;
                    cnt_nxt     = bus.in_addr + 1'b1;
                    scan_en_nxt = bus.in_en;
                end
            end
            SCAN: begin
                iss      = s1_load;
                iss_last = (cnt == ADDR_TOP);
                if (iss) begin
                    if (iss_last) state_nxt = IDLE;
                    else          cnt_nxt   = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            scan_en <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            scan_en <= scan_en_nxt;
        end
    end

    // The hi half carries en so a disabled beat is already zero in stage 1.
    decoder_predec #(.K(LO_W)) u_lo (.en(1'b1),   .addr(iss_addr[LO_W-1:0]),      .oh(lo_oh_d));
    decoder_predec #(.K(HI_W)) u_hi (.en(iss_en), .addr(iss_addr[ADDR_W-1:LO_W]), .oh(hi_oh_d));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            lo_oh_q     <= '0;
            hi_oh_q     <= '0;
            en_q        <= 1'b0;
            last_q      <= 1'b0;
        end else if (s1_load) begin
            vld_pipe[1] <= iss;
            if (iss) begin
                lo_oh_q <= lo_oh_d;
                hi_oh_q <= hi_oh_d;
                en_q    <= iss_en;
                last_q  <= iss_last;
            end
        end
    end

    for (genvar h = 0; h < HI_N; h++) begin : g_hi
        for (genvar l = 0; l < LO_N; l++) begin : g_lo
            assign y_d[h*LO_N+l] = en_q & hi_oh_q[h] & lo_oh_q[l];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[2] <= 1'b0;
            y_q         <= '0;
            last_y_q    <= 1'b0;
        end else if (s2_load) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                y_q      <= y_d;
                last_y_q <= last_q;
            end
        end
    end

`ifdef DECODE_ONEHOT_CHK_EN
    logic err_d;
    // y & (y-1) is nonzero exactly when more than one bit is set.
    assign err_d = (|(y_d & (y_d - 1'b1))) || (en_q && (y_d == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          out_err <= 1'b0;
        else if (s2_load) out_err <= vld_pipe[1] && err_d;
    end
`endif

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_pipe[2];
    assign bus.out_y     = y_q;
    assign bus.out_last  = last_y_q;
    assign busy          = (state == SCAN) || (|vld_pipe);

endmodule

// File: tb/tb_decoder_pipe_n.sv
// Directed bench for decoder_pipe_n at ADDR_W=6.
module tb_decoder_pipe_n;
    localparam int ADDR_W = 6;
    localparam int OUT_W  = 64;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef DECODE_ONEHOT_CHK_EN
    logic out_err;
`endif

    decoder_if #(.ADDR_W(ADDR_W)) bus();

    decoder_pipe_n #(.ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef DECODE_ONEHOT_CHK_EN
        ,
        .out_err(out_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Beats consumed by the sink, captured mid-cycle while inputs are stable.
    logic [OUT_W-1:0] gy[$];
    logic             gl[$];
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            gy.push_back(bus.out_y);
            gl.push_back(bus.out_last);
        end
    end

    function automatic logic [OUT_W-1:0] oh(input int i);
        logic [OUT_W-1:0] one;
        one = 64'd1;
        return one << i;
    endfunction

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_beats(input string tag, input int first, input int n, input bit scan);
        chk({tag, "_count"}, 64'(gy.size()), 64'(n));
        for (int k = 0; k < n && k < gy.size(); k++) begin
            chk($sformatf("%s_y%0d", tag, k), gy[k], oh(first + k));
            chk($sformatf("%s_last%0d", tag, k), 64'(gl[k]), 64'(!scan || (k == n - 1)));
        end
    endtask

    task automatic clr();
        gy.delete();
        gl.delete();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_en     = 1'b1;
        bus.in_scan   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_y",     bus.out_y,          64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
`ifdef DECODE_ONEHOT_CHK_EN
        chk("rst_out_err",   64'(out_err),       64'd0);
`endif
        cycn(2);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // 1: single decode of 0x2A, latency 2
        bus.in_valid = 1'b1; bus.in_addr = 6'h2A; bus.in_en = 1'b1; bus.in_scan = 1'b0;
        cyc();
        bus.in_valid = 1'b0;
        chk("t1_lat1_valid", 64'(bus.out_valid), 64'd0);
        cyc();
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_y",     bus.out_y,          oh(42));
        chk("t1_last",  64'(bus.out_last),  64'd1);
`ifdef DECODE_ONEHOT_CHK_EN
        chk("t1_err",   64'(out_err),       64'd0);
`endif
        cyc();
        chk("t1_drain_valid", 64'(bus.out_valid), 64'd0);
        clr();

        // 2: back-to-back singles 0..63
        for (int i = 0; i < 64; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 6'(i);
            #1;
            chk($sformatf("t2_in_ready%0d", i), 64'(bus.in_ready), 64'd1);
            cyc();
        end
        bus.in_valid = 1'b0;
        cycn(3);
        chk_beats("t2", 0, 64, 1'b0);
        clr();

        // 3: scan from 60
        bus.in_valid = 1'b1; bus.in_addr = 6'd60; bus.in_scan = 1'b1;
        cyc();
        bus.in_valid = 1'b0; bus.in_scan = 1'b0;
        chk("t3_rdy0", 64'(bus.in_ready), 64'd0);
        cyc();
        chk("t3_rdy1", 64'(bus.in_ready), 64'd0);
        cyc();
        chk("t3_rdy2", 64'(bus.in_ready), 64'd0);
        cyc();
        chk("t3_rdy_idle", 64'(bus.in_ready), 64'd1);
        chk("t3_busy",     64'(busy),         64'd1);
        cycn(3);
        chk("t3_busy_done", 64'(busy), 64'd0);
        chk_beats("t3", 60, 4, 1'b1);
        clr();

        // 4: scan from 50 under toggled then held back-pressure
        begin
            logic [OUT_W-1:0] hy;
            logic             hl;
            bus.in_valid = 1'b1; bus.in_addr = 6'd50; bus.in_scan = 1'b1;
            cyc();
            bus.in_valid = 1'b0; bus.in_scan = 1'b0;
            for (int j = 0; j < 8; j++) begin
                bus.out_ready = (j % 2 == 0);
                cyc();
            end
            bus.out_ready = 1'b0;
            hy = bus.out_y;
            hl = bus.out_last;
            chk("t4_hold_start_valid", 64'(bus.out_valid), 64'd1);
            for (int k = 0; k < 5; k++) begin
                cyc();
                chk($sformatf("t4_hold_valid%0d", k), 64'(bus.out_valid), 64'd1);
                chk($sformatf("t4_hold_y%0d", k),     bus.out_y,          hy);
                chk($sformatf("t4_hold_last%0d", k),  64'(bus.out_last),  64'(hl));
            end
            bus.out_ready = 1'b1;
            cycn(24);
            chk_beats("t4", 50, 14, 1'b1);
            clr();
        end

        // 4b: single-mode stall, in_ready drops once both stages are full
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_addr = 6'd3;
        #1;
        chk("t4b_rdy_a", 64'(bus.in_ready), 64'd1);
        cyc();
        bus.in_addr = 6'd4;
        #1;
        chk("t4b_rdy_b", 64'(bus.in_ready), 64'd1);
        cyc();
        bus.in_addr = 6'd5;
        #1;
        chk("t4b_rdy_full", 64'(bus.in_ready), 64'd0);
        cyc();
        chk("t4b_rdy_still", 64'(bus.in_ready), 64'd0);
        chk("t4b_y_held",    bus.out_y,          oh(3));
        chk("t4b_valid",     64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("t4b_rdy_release", 64'(bus.in_ready), 64'd1);
        cyc();
        bus.in_valid = 1'b0;
        cycn(4);
        chk_beats("t4b", 3, 3, 1'b0);
        clr();

        // 5: en=0 single
        bus.in_valid = 1'b1; bus.in_addr = 6'd5; bus.in_en = 1'b0;
        cyc();
        bus.in_valid = 1'b0; bus.in_en = 1'b1;
        cyc();
        chk("t5_valid", 64'(bus.out_valid), 64'd1);
        chk("t5_y",     bus.out_y,          64'd0);
        chk("t5_last",  64'(bus.out_last),  64'd1);
`ifdef DECODE_ONEHOT_CHK_EN
        chk("t5_err",   64'(out_err),       64'd0);
`endif
        cycn(2);
        clr();

        // 6: reset mid-scan at cnt=10, then a clean request
        bus.in_valid = 1'b1; bus.in_addr = 6'd0; bus.in_scan = 1'b1;
        cyc();
        bus.in_valid = 1'b0; bus.in_scan = 1'b0;
        cycn(9);
        chk("t6_pre_rst_y", bus.out_y, oh(8));
        rst = 1'b1;
        #1;
        chk("t6_rst_valid",    64'(bus.out_valid), 64'd0);
        chk("t6_rst_busy",     64'(busy),          64'd0);
        chk("t6_rst_y",        bus.out_y,          64'd0);
        chk("t6_rst_last",     64'(bus.out_last),  64'd0);
        cyc();
        rst = 1'b0;
        clr();
        bus.in_valid = 1'b1; bus.in_addr = 6'd17;
        #1;
        chk("t6_in_ready", 64'(bus.in_ready), 64'd1);
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        chk("t6_valid", 64'(bus.out_valid), 64'd1);
        chk("t6_y",     bus.out_y,          oh(17));
        chk("t6_last",  64'(bus.out_last),  64'd1);
        cycn(3);
        chk_beats("t6", 17, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
